// File: rtl/mmio_sha2_pkg.sv
// Shared types for the SHA-2 MMIO front-end: register map, CTRL/STAT layouts and
// the FIFO entry format.
package mmio_sha2_pkg;

    typedef enum logic [2:0] {
        REG_CTRL      = 3'd0,
        REG_STAT      = 3'd1,
        REG_DATA_I_LO = 3'd2,
        REG_DATA_I_HI = 3'd3,
        REG_DATA_O_LO = 3'd4,
        REG_DATA_O_HI = 3'd5,
        REG_THRESH    = 3'd6,
        REG_ID        = 3'd7
    } reg_idx_e;

    typedef struct packed {
        logic        ie_lvl;
        logic        ie_done;
        logic [24:0] rsvd;
        logic        last;
        logic [1:0]  mode;
        logic        flush;
        logic        en;
    } ctrl_t;

    typedef struct packed {
        logic        lvl_pend;
        logic        done_pend;
        logic [12:0] rsvd_hi;
        logic        ovf;
        logic [3:0]  rsvd_lo;
        logic        out_valid;
        logic        empty;
        logic        full;
        logic [8:0]  count;
    } stat_t;

    typedef struct packed {
        logic [1:0]  mode;
        logic        last;
        logic [63:0] data;
    } fifo_entry_t;

    localparam int CNT_W = 9;

    // Flush is a command, not state, and reserved bits always read back as zero.
    function automatic ctrl_t ctrl_from_bus(input logic [31:0] w);
        ctrl_t c;
        c       = ctrl_t'(w);
        c.flush = 1'b0;
        c.rsvd  = '0;
        return c;
    endfunction

endpackage

// File: rtl/mmio_fifo.sv
// Synchronous show-ahead FIFO with occupancy count, flush and wrap-around pointers.
// DEPTH must be a power of two so the pointers wrap naturally.
module mmio_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic                    flush_i,
    input  logic [W-1:0]            wdata_i,
    output logic [W-1:0]            rdata_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic [$clog2(DEPTH):0]  count_d_o,
    output logic                    full_o,
    output logic                    empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          wr_acc, rd_acc;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign wr_acc = push_i && !flush_i && (!full_o || pop_i);
    assign rd_acc = pop_i && !flush_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; stale words are unreachable because
    // the count gates every read of the head.
    always_ff @(posedge clk_i) begin
        if (wr_acc) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o   = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign count_d_o = count_d;

endmodule

// File: rtl/mmio_sha2_fifo.sv
// MMIO front-end for the SHA-2 core: register file, tagged input word FIFO,
// digest read-out handshake, sticky flags and maskable interrupts.
module mmio_sha2_fifo
    import mmio_sha2_pkg::*;
#(
    parameter int          A_WIDTH = 8,
    parameter int          D_WIDTH = 32,
    parameter int          F_DEPTH = 8,
    parameter logic [31:0] ID_VAL  = 32'h5348_0002
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               wr_en_i,
    input  logic [A_WIDTH-1:0] wr_addr_i,
    input  logic [D_WIDTH-1:0] wr_data_i,
    input  logic               rd_en_i,
    input  logic [A_WIDTH-1:0] rd_addr_i,
    output logic [D_WIDTH-1:0] rd_data_o,
    output logic               intr_o,
    output logic               core_rst_n_o,
    output logic [1:0]         core_mode_o,
    output logic               core_last_o,
    output logic [63:0]        core_data_o,
    output logic               core_valid_o,
    input  logic               core_ready_i,
    input  logic [63:0]        core_out_data_i,
    input  logic               core_out_valid_i,
    output logic               core_out_ready_o
);

    localparam int FCW = $clog2(F_DEPTH) + 1;

    ctrl_t             ctrl_q, ctrl_d;
    logic [31:0]       data_lo_q, data_lo_d, data_hi_q, data_hi_d;
    logic [CNT_W-1:0]  thresh_q, thresh_d;
    logic              ovf_q, ovf_d;
    logic              done_pend_q, done_pend_d;
    logic              lvl_pend_q, lvl_pend_d;
    logic              intr_q, intr_d;
    logic              out_ready_q, out_ready_d;
    logic              out_valid_prev_q;
    logic [31:0]       rd_data_q, rd_data_d;

    reg_idx_e          wr_idx, rd_idx;
    logic              push, pop, flush, out_rise, lvl_fall;
    fifo_entry_t       fifo_wdata, fifo_head, head_vis;
    logic [FCW-1:0]    fifo_count, fifo_count_d;
    logic [CNT_W-1:0]  count, count_d;
    logic              fifo_full, fifo_empty;
    stat_t             stat;
    logic              unused_addr;

    assign wr_idx = reg_idx_e'(wr_addr_i[4:2]);
    assign rd_idx = reg_idx_e'(rd_addr_i[4:2]);
    assign unused_addr = ^wr_addr_i ^ ^rd_addr_i;

    assign push  = wr_en_i && (wr_idx == REG_DATA_I_HI);
    assign flush = wr_en_i && (wr_idx == REG_CTRL) && wr_data_i[1];
    assign pop   = core_valid_o && core_ready_i;

    // The freshly written HI word goes straight into the FIFO alongside the staged LO word.
    assign fifo_wdata = '{mode: ctrl_q.mode, last: ctrl_q.last, data: {wr_data_i, data_lo_q}};

    mmio_fifo #(
        .W     ($bits(fifo_entry_t)),
        .DEPTH (F_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (push),
        .pop_i     (pop),
        .flush_i   (flush),
        .wdata_i   (fifo_wdata),
        .rdata_o   (fifo_head),
        .count_o   (fifo_count),
        .count_d_o (fifo_count_d),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign count    = CNT_W'(fifo_count);
    assign count_d  = CNT_W'(fifo_count_d);
    assign lvl_fall = (count > thresh_q) && (count_d <= thresh_q);
    assign out_rise = core_out_valid_i && !out_valid_prev_q;

    always_comb begin
        stat           = '0;
        stat.lvl_pend  = lvl_pend_q;
        stat.done_pend = done_pend_q;
        stat.ovf       = ovf_q;
        stat.out_valid = core_out_valid_i;
        stat.empty     = fifo_empty;
        stat.full      = fifo_full;
        stat.count     = count;
    end

    // NOTE: every next-state value takes its default first, so no path can infer a latch.
    always_comb begin
        ctrl_d      = ctrl_q;
        data_lo_d   = data_lo_q;
        data_hi_d   = data_hi_q;
        thresh_d    = thresh_q;
        ovf_d       = ovf_q;
        done_pend_d = done_pend_q;
        lvl_pend_d  = lvl_pend_q;
        rd_data_d   = rd_data_q;

        if (wr_en_i) begin
            case (wr_idx)
                REG_CTRL:      ctrl_d    = ctrl_from_bus(wr_data_i);
                REG_STAT: begin
                    if (wr_data_i[16]) ovf_d       = 1'b0;
                    if (wr_data_i[30]) done_pend_d = 1'b0;
                    if (wr_data_i[31]) lvl_pend_d  = 1'b0;
                end
                REG_DATA_I_LO: data_lo_d = wr_data_i;
                REG_DATA_I_HI: data_hi_d = wr_data_i;
                REG_THRESH:    thresh_d  = wr_data_i[CNT_W-1:0];
                default:       ;
            endcase
        end

        // Event sets come after the W1C clears so a coincident set wins.
        if (push && fifo_full && !pop) ovf_d = 1'b1;
        if (out_rise)                  done_pend_d = 1'b1;
        if (lvl_fall)                  lvl_pend_d  = 1'b1;

        intr_d      = (done_pend_d && ctrl_d.ie_done) || (lvl_pend_d && ctrl_d.ie_lvl);
        out_ready_d = rd_en_i && (rd_idx == REG_DATA_O_HI) && core_out_valid_i;

        if (rd_en_i) begin
            case (rd_idx)
                REG_CTRL:      rd_data_d = ctrl_q;
                REG_STAT:      rd_data_d = stat;
                REG_DATA_I_LO: rd_data_d = data_lo_q;
                REG_DATA_I_HI: rd_data_d = data_hi_q;
                REG_DATA_O_LO: rd_data_d = core_out_data_i[31:0];
                REG_DATA_O_HI: rd_data_d = core_out_data_i[63:32];
                REG_THRESH:    rd_data_d = 32'(thresh_q);
                REG_ID:        rd_data_d = ID_VAL;
                default:       rd_data_d = '0;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_q           <= '0;
            data_lo_q        <= '0;
            data_hi_q        <= '0;
            thresh_q         <= '0;
            ovf_q            <= 1'b0;
            done_pend_q      <= 1'b0;
            lvl_pend_q       <= 1'b0;
            intr_q           <= 1'b0;
            out_ready_q      <= 1'b0;
            out_valid_prev_q <= 1'b0;
            rd_data_q        <= '0;
        end else begin
            ctrl_q           <= ctrl_d;
            data_lo_q        <= data_lo_d;
            data_hi_q        <= data_hi_d;
            thresh_q         <= thresh_d;
            ovf_q            <= ovf_d;
            done_pend_q      <= done_pend_d;
            lvl_pend_q       <= lvl_pend_d;
            intr_q           <= intr_d;
            out_ready_q      <= out_ready_d;
            out_valid_prev_q <= core_out_valid_i;
            rd_data_q        <= rd_data_d;
        end
    end

    assign head_vis         = fifo_empty ? '0 : fifo_head;
    assign core_rst_n_o     = ctrl_q.en;
    assign core_valid_o     = !fifo_empty && ctrl_q.en;
    assign core_mode_o      = head_vis.mode;
    assign core_last_o      = head_vis.last;
    assign core_data_o      = head_vis.data;
    assign core_out_ready_o = out_ready_q;
    assign intr_o           = intr_q;
    assign rd_data_o        = rd_data_q;

endmodule

// File: tb/tb_mmio_sha2_fifo.sv
// Directed, table-driven bench for mmio_sha2_fifo with hand-computed expectations.
module tb_mmio_sha2_fifo;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        wr_en_i = 1'b0;
    logic [7:0]  wr_addr_i = '0;
    logic [31:0] wr_data_i = '0;
    logic        rd_en_i = 1'b0;
    logic [7:0]  rd_addr_i = '0;
    logic [31:0] rd_data_o;
    logic        intr_o;
    logic        core_rst_n_o;
    logic [1:0]  core_mode_o;
    logic        core_last_o;
    logic [63:0] core_data_o;
    logic        core_valid_o;
    logic        core_ready_i = 1'b0;
    logic [63:0] core_out_data_i = '0;
    logic        core_out_valid_i = 1'b0;
    logic        core_out_ready_o;

    localparam logic [7:0] A_CTRL = 8'h00, A_STAT = 8'h04, A_ILO = 8'h08, A_IHI = 8'h0C;
    localparam logic [7:0] A_OLO = 8'h10, A_OHI = 8'h14, A_THR = 8'h18, A_ID = 8'h1C;

    mmio_sha2_fifo dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .wr_en_i          (wr_en_i),
        .wr_addr_i        (wr_addr_i),
        .wr_data_i        (wr_data_i),
        .rd_en_i          (rd_en_i),
        .rd_addr_i        (rd_addr_i),
        .rd_data_o        (rd_data_o),
        .intr_o           (intr_o),
        .core_rst_n_o     (core_rst_n_o),
        .core_mode_o      (core_mode_o),
        .core_last_o      (core_last_o),
        .core_data_o      (core_data_o),
        .core_valid_o     (core_valid_o),
        .core_ready_i     (core_ready_i),
        .core_out_data_i  (core_out_data_i),
        .core_out_valid_i (core_out_valid_i),
        .core_out_ready_o (core_out_ready_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk_i);
        wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d;
        @(negedge clk_i);
        wr_en_i = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk_i);
        rd_en_i = 1'b1; rd_addr_i = a;
        @(negedge clk_i);
        rd_en_i = 1'b0;
        d = rd_data_o;
    endtask

    task automatic push(input logic [31:0] lo, input logic [31:0] hi);
        wr(A_ILO, lo);
        wr(A_IHI, hi);
    endtask

    task automatic check_reg(input string name, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] v;
        rd(a, v);
        check(name, 64'(v), 64'(exp));
    endtask

    typedef struct {
        string       name;
        logic [7:0]  addr;
        logic [31:0] exp;
    } rd_vec_t;

    typedef struct {
        logic [31:0] ctrl;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [63:0] exp_data;
        logic [1:0]  exp_mode;
        logic        exp_last;
    } beat_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rd_vec_t rvec [8];
        beat_t   beats [3];

        rvec[0] = '{"rst_ctrl",   A_CTRL, 32'h0000_0000};
        rvec[1] = '{"rst_stat",   A_STAT, 32'h0000_0400};
        rvec[2] = '{"rst_di_lo",  A_ILO,  32'h0000_0000};
        rvec[3] = '{"rst_di_hi",  A_IHI,  32'h0000_0000};
        rvec[4] = '{"rst_do_lo",  A_OLO,  32'h0000_0000};
        rvec[5] = '{"rst_do_hi",  A_OHI,  32'h0000_0000};
        rvec[6] = '{"rst_thresh", A_THR,  32'h0000_0000};
        rvec[7] = '{"rst_id",     A_ID,   32'h5348_0002};

        beats[0] = '{32'h0000_0001, 32'hA000_0001, 32'hB000_0001, 64'hB000_0001_A000_0001, 2'd0, 1'b0};
        beats[1] = '{32'h0000_0005, 32'hA000_0002, 32'hB000_0002, 64'hB000_0002_A000_0002, 2'd1, 1'b0};
        beats[2] = '{32'h0000_0019, 32'hA000_0003, 32'hB000_0003, 64'hB000_0003_A000_0003, 2'd2, 1'b1};

        // Reset state
        repeat (3) @(negedge clk_i);
        check("rst_intr", 64'(intr_o), 64'd0);
        check("rst_core_rst_n", 64'(core_rst_n_o), 64'd0);
        check("rst_core_valid", 64'(core_valid_o), 64'd0);
        check("rst_core_data", core_data_o, 64'd0);
        check("rst_out_ready", 64'(core_out_ready_o), 64'd0);
        rst_i = 1'b0;
        for (int i = 0; i < 8; i++) check_reg(rvec[i].name, rvec[i].addr, rvec[i].exp);

        // Fill to full, overflow, W1C of ovf, flush
        wr(A_CTRL, 32'h0000_0001);
        check("en_core_rst_n", 64'(core_rst_n_o), 64'd1);
        for (int i = 0; i < 8; i++) push(32'(i), 32'h100 + 32'(i));
        check_reg("full_stat", A_STAT, 32'h0000_0208);
        check("full_head", core_data_o, 64'h0000_0100_0000_0000);
        push(32'h55, 32'h66);
        check_reg("ovf_stat", A_STAT, 32'h0001_0208);
        check("ovf_head", core_data_o, 64'h0000_0100_0000_0000);
        wr(A_STAT, 32'h0001_0000);
        check_reg("ovf_clear", A_STAT, 32'h0000_0208);
        wr(A_CTRL, 32'h0000_0003);
        check("flush_valid", 64'(core_valid_o), 64'd0);
        check_reg("flush_stat", A_STAT, 32'h8000_0400);
        check_reg("flush_ctrl", A_CTRL, 32'h0000_0001);

        // Tagged beats delivered in order
        for (int i = 0; i < 3; i++) begin
            wr(A_CTRL, beats[i].ctrl);
            push(beats[i].lo, beats[i].hi);
        end
        wr(A_CTRL, 32'h0000_0001);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("beat%0d_valid", i), 64'(core_valid_o), 64'd1);
            check($sformatf("beat%0d_data", i), core_data_o, beats[i].exp_data);
            check($sformatf("beat%0d_mode", i), 64'(core_mode_o), 64'(beats[i].exp_mode));
            check($sformatf("beat%0d_last", i), 64'(core_last_o), 64'(beats[i].exp_last));
            core_ready_i = 1'b1;
            @(negedge clk_i);
            core_ready_i = 1'b0;
        end
        check("beats_drained", 64'(core_valid_o), 64'd0);

        // Level interrupt on the 3->2 crossing with THRESH=2
        check_reg("lvl_pre_stat", A_STAT, 32'h8000_0400);
        wr(A_THR, 32'd2);
        wr(A_STAT, 32'h8000_0000);
        wr(A_CTRL, 32'h8000_0001);
        for (int i = 0; i < 4; i++) push(32'h20 + 32'(i), 32'h30 + 32'(i));
        check("lvl_fill_intr", 64'(intr_o), 64'd0);
        check_reg("lvl_fill_stat", A_STAT, 32'h0000_0004);
        core_ready_i = 1'b1;
        @(negedge clk_i);
        check("lvl_4to3_intr", 64'(intr_o), 64'd0);
        @(negedge clk_i);
        check("lvl_3to2_intr", 64'(intr_o), 64'd1);
        repeat (3) @(negedge clk_i);
        core_ready_i = 1'b0;
        check_reg("lvl_stat", A_STAT, 32'h8000_0400);
        wr(A_STAT, 32'h8000_0000);
        check("lvl_w1c_intr", 64'(intr_o), 64'd0);

        // Digest read-out and done interrupt
        wr(A_CTRL, 32'h4000_0001);
        core_out_data_i  = 64'hDEAD_BEEF_CAFE_F00D;
        core_out_valid_i = 1'b1;
        @(negedge clk_i);
        check("done_intr", 64'(intr_o), 64'd1);
        check_reg("done_stat", A_STAT, 32'h4000_0C00);
        check_reg("dout_lo", A_OLO, 32'hCAFE_F00D);
        check("dout_lo_noready", 64'(core_out_ready_o), 64'd0);
        check_reg("dout_hi", A_OHI, 32'hDEAD_BEEF);
        check("dout_hi_ready", 64'(core_out_ready_o), 64'd1);
        @(negedge clk_i);
        check("dout_ready_pulse", 64'(core_out_ready_o), 64'd0);
        core_out_valid_i = 1'b0;
        check_reg("dout_hi_novalid", A_OHI, 32'hDEAD_BEEF);
        check("dout_novalid_ready", 64'(core_out_ready_o), 64'd0);
        wr(A_STAT, 32'h4000_0000);
        check("done_w1c_intr", 64'(intr_o), 64'd0);

        // Push while full and popping, then flush mid-burst
        wr(A_CTRL, 32'h0000_0001);
        for (int i = 0; i < 8; i++) push(32'h10 + 32'(i), 32'h200 + 32'(i));
        @(negedge clk_i);
        core_ready_i = 1'b1;
        wr_en_i = 1'b1; wr_addr_i = A_IHI; wr_data_i = 32'h2FF;
        @(negedge clk_i);
        wr_en_i = 1'b0;
        core_ready_i = 1'b0;
        check("fullpp_head", core_data_o, 64'h0000_0201_0000_0011);
        check_reg("fullpp_stat", A_STAT, 32'h0000_0208);
        core_ready_i = 1'b1;
        @(negedge clk_i);
        wr(A_CTRL, 32'h0000_0003);
        check("midflush_valid", 64'(core_valid_o), 64'd0);
        core_ready_i = 1'b0;
        check_reg("midflush_stat", A_STAT, 32'h8000_0400);
        wr(A_STAT, 32'h8000_0000);

        // en=0 retains contents and blocks pops
        push(32'h41, 32'h51);
        push(32'h42, 32'h52);
        wr(A_CTRL, 32'h0000_0000);
        check("dis_core_rst_n", 64'(core_rst_n_o), 64'd0);
        check("dis_valid", 64'(core_valid_o), 64'd0);
        core_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        core_ready_i = 1'b0;
        check_reg("dis_stat", A_STAT, 32'h0000_0002);
        wr(A_CTRL, 32'h0000_0001);
        check("reen_head", core_data_o, 64'h0000_0051_0000_0041);

        // Asynchronous reset mid-burst
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        check("arst_valid", 64'(core_valid_o), 64'd0);
        check("arst_data", core_data_o, 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        check_reg("arst_stat", A_STAT, 32'h0000_0400);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
